// File: rtl/control_subcmd_readarea.sv
// ---------------------------------------------------------------------------
// control_subcmd_readarea
//
// Framebuffer area reader. Walks a rectangle (x1, y1, width, height) in the
// same order the fill path writes it (rows top-down from y1+H-1, columns
// right-to-left from x1+W-1, bytes BYTES_PER_PIXEL-1 down to 0), issues one
// RAM read per byte and streams each byte out on a valid/ready interface.
// Uses the enable / done / ack handshake shared by the control subcommands.
//
// Build option:
//   READAREA_PREFETCH_EN  when defined, a 2-entry output FIFO lets reads
//                         overlap with output transfers (1 byte/cycle with
//                         ready held high). Undefined: single output buffer,
//                         one byte every 3 cycles.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   enable, ack           level start/hold request; acknowledge of done
//   x1, y1                left column / bottom row of the area
//   width, height         area size; 0 encodes the full panel dimension
//   row, column, pixel    RAM read address
//   ram_read_enable       read strobe, address valid this cycle
//   ram_access_start      pulse on the first read of a command
//   ram_data_in           read data, valid one cycle after the strobe
//   data_out, data_out_valid, data_out_ready   byte stream out
//   done                  all bytes of the area accepted downstream
// ---------------------------------------------------------------------------
package params_pkg;
    localparam int PIXEL_HEIGHT    = 8;
    localparam int BYTES_PER_PIXEL = 3;
endpackage

module control_subcmd_readarea #(
    parameter  int PIXEL_WIDTH     = 64,
    parameter  int PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
    parameter  int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
    localparam int COL_W           = $clog2(PIXEL_WIDTH),
    localparam int ROW_W           = $clog2(PIXEL_HEIGHT),
    localparam int PIX_W           = $clog2(BYTES_PER_PIXEL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ack,
    input  logic [COL_W-1:0] x1,
    input  logic [ROW_W-1:0] y1,
    input  logic [COL_W-1:0] width,
    input  logic [ROW_W-1:0] height,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] column,
    output logic [PIX_W-1:0] pixel,
    output logic             ram_read_enable,
    output logic             ram_access_start,
    input  logic [7:0]       ram_data_in,
    output logic [7:0]       data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready,
    output logic             done
);

    localparam logic [COL_W-1:0] COL_FULL_M1 = COL_W'(PIXEL_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_FULL_M1 = ROW_W'(PIXEL_HEIGHT - 1);
    localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(BYTES_PER_PIXEL - 1);

    logic [COL_W-1:0] w_m1;
    logic [ROW_W-1:0] h_m1;
    logic [COL_W-1:0] w_m1_q, col_start_q, col_q, col_left_q;
    logic [ROW_W-1:0] row_q, row_left_q;
    logic [PIX_W-1:0] pix_q;
    logic             start, adv, rd_en, last_addr;
    logic             arm_q, arm_d, first_q;

    // Sizes are kept as count-1 so a zero size (full panel) needs no extra bit.
    assign w_m1 = (width  == '0) ? COL_FULL_M1 : width  - COL_W'(1);
    assign h_m1 = (height == '0) ? ROW_FULL_M1 : height - ROW_W'(1);

    assign last_addr = (pix_q == '0) && (col_left_q == '0) && (row_left_q == '0);

    // Address walker: loaded on command start, stepped by adv. Address sums
    // wrap modulo the field width on purpose (no clipping).
    always_ff @(posedge clk) begin
        if (reset) begin
            w_m1_q      <= '0;
            col_start_q <= '0;
            col_q       <= '0;
            col_left_q  <= '0;
            row_q       <= '0;
            row_left_q  <= '0;
            pix_q       <= '0;
        end else if (start) begin
            w_m1_q      <= w_m1;
            col_start_q <= x1 + w_m1;
            col_q       <= x1 + w_m1;
            col_left_q  <= w_m1;
            row_q       <= y1 + h_m1;
            row_left_q  <= h_m1;
            pix_q       <= PIX_LAST;
        end else if (adv) begin
            if (pix_q != '0) begin
                pix_q <= pix_q - PIX_W'(1);
            end else begin
                pix_q <= PIX_LAST;
                if (col_left_q != '0) begin
                    col_q      <= col_q - COL_W'(1);
                    col_left_q <= col_left_q - COL_W'(1);
                end else begin
                    col_q      <= col_start_q;
                    col_left_q <= w_m1_q;
                    row_q      <= row_q - ROW_W'(1);
                    row_left_q <= row_left_q - ROW_W'(1);
                end
            end
        end
    end

    // first_q marks that the next read is the first one of the command.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_q <= 1'b0;
        end else if (start) begin
            first_q <= 1'b1;
        end else if (rd_en) begin
            first_q <= 1'b0;
        end
    end

    assign row              = row_q;
    assign column           = col_q;
    assign pixel            = pix_q;
    assign ram_read_enable  = rd_en;
    assign ram_access_start = rd_en && first_q;

`ifdef READAREA_PREFETCH_EN

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] fifo_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic       inflight_q, issued_all_q;
    logic [1:0] cnt_q, occ;
    logic       pop, flush;

    assign pop = (cnt_q != 2'd0) && data_out_ready;
    // Outstanding bytes after this cycle's pop; a read may only be issued
    // when it is guaranteed a FIFO slot on return.
    assign occ = 2'(inflight_q) + cnt_q - 2'(pop);

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        start   = 1'b0;
        adv     = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    arm_d = 1'b1;
                end else if (arm_q) begin
                    start   = 1'b1;
                    arm_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (!issued_all_q && (cnt_q != 2'd2) && (occ < 2'd2)) begin
                        rd_en = 1'b1;
                        adv   = !last_addr;
                    end
                    if (issued_all_q && !inflight_q && (cnt_q == 2'd1) && pop) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            arm_q        <= 1'b0;
            cnt_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            inflight_q   <= 1'b0;
            issued_all_q <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            if (flush || start) begin
                cnt_q        <= 2'd0;
                wr_ptr_q     <= 1'b0;
                rd_ptr_q     <= 1'b0;
                inflight_q   <= 1'b0;
                issued_all_q <= 1'b0;
            end else begin
                inflight_q <= rd_en;
                if (rd_en && last_addr) begin
                    issued_all_q <= 1'b1;
                end
                if (inflight_q) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);
            end
        end
    end

    // FIFO storage: contents are qualified by cnt_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (inflight_q && !flush) begin
            fifo_q[wr_ptr_q] <= ram_data_in;
        end
    end

    assign data_out_valid = (cnt_q != 2'd0);
    assign data_out       = data_out_valid ? fifo_q[rd_ptr_q] : 8'd0;
    assign done           = (state_q == S_DONE);

`else

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       load_data, xfer;
    logic       valid_q;
    logic [7:0] data_q;

    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q;
        start     = 1'b0;
        adv       = 1'b0;
        rd_en     = 1'b0;
        load_data = 1'b0;
        xfer      = valid_q && data_out_ready;
        case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    arm_d = 1'b1;
                end else if (arm_q) begin
                    start   = 1'b1;
                    arm_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    rd_en   = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    load_data = 1'b1;
                    state_d   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (last_addr) begin
                        state_d = S_DONE;
                    end else begin
                        adv     = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The output buffer is valid exactly while the FSM sits in PRESENT, so
    // a transfer or an abort both drop valid on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            arm_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            valid_q <= (state_d == S_PRESENT);
            if (load_data) begin
                data_q <= ram_data_in;
            end
        end
    end

    assign data_out_valid = valid_q;
    assign data_out       = data_q;
    assign done           = (state_q == S_DONE);

`endif

endmodule

// File: tb/tb_control_subcmd_readarea.sv
// ---------------------------------------------------------------------------
// tb_control_subcmd_readarea
//
// Bench for control_subcmd_readarea with a 4-column panel. The RAM model
// returns {row, column, pixel} for each read one cycle after the strobe; the
// expected byte stream is generated from the area geometry with plain loops.
// ---------------------------------------------------------------------------
module tb_control_subcmd_readarea;

    localparam int W   = 4;
    localparam int H   = params_pkg::PIXEL_HEIGHT;
    localparam int BPP = params_pkg::BYTES_PER_PIXEL;
    localparam int CB  = $clog2(W);
    localparam int RB  = $clog2(H);
    localparam int PB  = $clog2(BPP);

    logic          clk;
    logic          reset;
    logic          enable;
    logic          ack;
    logic [CB-1:0] x1;
    logic [RB-1:0] y1;
    logic [CB-1:0] width;
    logic [RB-1:0] height;
    logic [RB-1:0] row;
    logic [CB-1:0] column;
    logic [PB-1:0] pixel;
    logic          ram_read_enable;
    logic          ram_access_start;
    logic [7:0]    ram_data_in;
    logic [7:0]    data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          done;

    control_subcmd_readarea #(
        .PIXEL_WIDTH(W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .ack             (ack),
        .x1              (x1),
        .y1              (y1),
        .width           (width),
        .height          (height),
        .row             (row),
        .column          (column),
        .pixel           (pixel),
        .ram_read_enable (ram_read_enable),
        .ram_access_start(ram_access_start),
        .ram_data_in     (ram_data_in),
        .data_out        (data_out),
        .data_out_valid  (data_out_valid),
        .data_out_ready  (data_out_ready),
        .done            (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: 1-cycle read latency, contents encode the address.
    initial ram_data_in = 8'd0;
    always @(posedge clk) begin
        if (ram_read_enable) ram_data_in <= 8'({row, column, pixel});
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Stimulus modes for ready/ack, applied 2 time units after each edge.
    int drv_k     = 0;
    int rmode     = 0;   // 0 high, 1 toggle every 2 cycles, 2 random, 3 low
    bit ack_force = 1'b0;
    bit ack_noise = 1'b0;

    initial begin
        data_out_ready = 1'b0;
        ack            = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            drv_k++;
            case (rmode)
                0:       data_out_ready = 1'b1;
                1:       data_out_ready = ((drv_k / 2) % 2) == 0;
                2:       data_out_ready = 1'($urandom_range(0, 1));
                default: data_out_ready = 1'b0;
            endcase
            ack = ack_force | (ack_noise & ($urandom_range(0, 3) == 0));
        end
    end

    // Monitor: cumulative event counts and accepted bytes, sampled mid-cycle.
    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         mon_cyc  = 0;
    int         rd_cnt   = 0;
    int         acc_cnt  = 0;
    int         done_cnt = 0;
    int         hold_n   = 0;
    int         hold_err = 0;
    bit         hold_v   = 1'b0;
    logic [7:0] hold_d   = 8'd0;
    bit         mon_chk  = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (ram_read_enable)  rd_cnt++;
            if (ram_access_start) acc_cnt++;
            if (done)             done_cnt++;
            if (data_out_valid && data_out_ready) begin
                rx_q.push_back(data_out);
                rx_t.push_back(mon_cyc);
            end
            if (hold_v && mon_chk) begin
                hold_n++;
                if (!data_out_valid || data_out != hold_d) hold_err++;
            end
            hold_v = mon_chk && data_out_valid && !data_out_ready;
            hold_d = data_out;
        end
    end

    // Reference model of the traversal.
    int exp_q [$];

    function automatic int enc(input int r, input int c, input int p);
        return (r << (CB + PB)) | (c << PB) | p;
    endfunction

    function automatic void build_exp(input int ax, input int ay, input int aw, input int ah);
        int ww, hh;
        ww = (aw == 0) ? W : aw;
        hh = (ah == 0) ? H : ah;
        exp_q.delete();
        for (int i = hh - 1; i >= 0; i--)
            for (int j = ww - 1; j >= 0; j--)
                for (int p = BPP - 1; p >= 0; p--)
                    exp_q.push_back(enc((ay + i) % (1 << RB), (ax + j) % (1 << CB), p));
    endfunction

    task automatic cmp_stream(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int got;
            got = (base + i < rx_q.size()) ? int'(rx_q[base + i]) : -1;
            check(tag, got, exp_q[i]);
            if (got != exp_q[i]) break;
        end
    endtask

    // One complete command: arm, start, latency, stream, done, ack handshake.
    task automatic run_cmd(input int ax, input int ay, input int aw, input int ah,
                           input int rm, input bit noise, input bit rowchk,
                           output int base);
        int lat, cyc, limit, rd0, acc0, n, rs;
        bit got;
        enable = 1'b0;
        @(posedge clk); #1;
        x1     = CB'(ax);
        y1     = RB'(ay);
        width  = CB'(aw);
        height = RB'(ah);
        rmode     = rm;
        ack_noise = noise;
        build_exp(ax, ay, aw, ah);
        base   = rx_q.size();
        rd0    = rd_cnt;
        acc0   = acc_cnt;
        enable = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (data_out_valid) got = 1'b1;
        end
        check("latency", lat, 3);
        limit = exp_q.size() * 8 + 50;
        cyc = 0;
        while (!done && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done", int'(done), 1);
        n = rx_q.size() - base;
        check("nbytes", n, exp_q.size());
        cmp_stream("stream", base, exp_q.size());
        check("nreads", rd_cnt - rd0, exp_q.size());
        check("acc_start", acc_cnt - acc0, 1);
        if (rowchk && n > 0) begin
            rs = rx_t[base];
            for (int i = 1; i < n; i++) begin
                if ((rx_q[base + i] >> (CB + PB)) != (rx_q[base + i - 1] >> (CB + PB))) begin
                    check("row_gap", int'((rx_t[base + i] - rs) <= 3 * W * BPP), 1);
                    rs = rx_t[base + i];
                end
            end
        end
        // Ack with enable still high: done clears, no new command starts.
        ack_noise = 1'b0;
        ack_force = 1'b1;
        @(posedge clk); #1;
        ack_force = 1'b0;
        check("done_clr", int'(done), 0);
        rd0 = rd_cnt;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("no_restart", rd_cnt - rd0, 0);
        enable = 1'b0;
    endtask

    int base, cyc, rd0, dn0;
    bit got;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        x1     = '0;
        y1     = '0;
        width  = '0;
        height = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done",  int'(done), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_rd",    int'(ram_read_enable), 0);
        check("rst_row",   int'(row), 0);
        check("rst_col",   int'(column), 0);
        check("rst_pix",   int'(pixel), 0);
        check("rst_data",  int'(data_out), 0);
        reset = 1'b0;

        // Full panel, ready high.
        run_cmd(0, 0, 0, 0, 0, 1'b0, 1'b1, base);
        check("first_byte", (base < rx_q.size()) ? int'(rx_q[base]) : -1, enc(H - 1, W - 1, BPP - 1));

        // Sub-area: columns 2,1 of row 1.
        run_cmd(1, 1, 2, 1, 0, 1'b0, 1'b0, base);

        // Backpressure: ready toggling every 2 cycles.
        run_cmd(0, 0, 0, 0, 1, 1'b0, 1'b0, base);
        check("hold_seen", int'(hold_n > 0), 1);
        check("hold_stable", hold_err, 0);

        // Abort after 3 accepted bytes.
        enable = 1'b0;
        @(posedge clk); #1;
        x1 = '0; y1 = '0; width = '0; height = '0;
        rmode = 0;
        build_exp(0, 0, 0, 0);
        base   = rx_q.size();
        dn0    = done_cnt;
        enable = 1'b1;
        cyc = 0;
        while (rx_q.size() - base < 3 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reach", int'(rx_q.size() - base >= 3), 1);
        rd0    = rd_cnt;
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", int'(data_out_valid), 0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("abort_rd", rd_cnt - rd0, 0);
        check("abort_done", done_cnt - dn0, 0);
        cmp_stream("abort_stream", base, 3);

        // Reset while a byte is presented and held by backpressure.
        @(posedge clk); #1;
        rmode  = 3;
        enable = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (data_out_valid) got = 1'b1;
        end
        check("rst_reach", int'(got), 1);
        mon_chk = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        enable = 1'b0;
        check("mrst_row",   int'(row), 0);
        check("mrst_col",   int'(column), 0);
        check("mrst_pix",   int'(pixel), 0);
        check("mrst_rd",    int'(ram_read_enable), 0);
        check("mrst_acc",   int'(ram_access_start), 0);
        check("mrst_data",  int'(data_out), 0);
        check("mrst_valid", int'(data_out_valid), 0);
        check("mrst_done",  int'(done), 0);
        @(posedge clk); #1;
        mon_chk = 1'b1;
        run_cmd(0, 0, 0, 0, 0, 1'b0, 1'b1, base);

        // Random areas with random ready and stray acks.
        for (int k = 0; k < 6; k++) begin
            run_cmd($urandom_range(0, W - 1), $urandom_range(0, H - 1),
                    $urandom_range(0, W - 1), $urandom_range(0, H - 1),
                    2, 1'b1, 1'b0, base);
        end
        check("hold_stable_all", hold_err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/control_subcmd_readarea.md
Name: control_subcmd_readarea

Overview:
- Framebuffer reader counterpart of the fill-area subcommand.
- Given a rectangle (x1, y1, width, height), it walks the same row/column/pixel address space that the fill/write path uses, issues RAM reads, and streams each byte out over a valid/ready byte interface (e.g. toward the UART readback transmitter).
- Sits under the control command decoder.
- Uses the same enable / done / ack handshake as the other control subcommands.

Parameters:
- PIXEL_WIDTH, 64, panel columns; column bits = $clog2(PIXEL_WIDTH).
- PIXEL_HEIGHT, params_pkg::PIXEL_HEIGHT, panel rows; row bits = $clog2(PIXEL_HEIGHT).
- BYTES_PER_PIXEL, params_pkg::BYTES_PER_PIXEL, bytes per pixel; pixel bits = $clog2(BYTES_PER_PIXEL).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start/hold request from decoder; level-sensitive.
- ack  in  1  decoder acknowledge of done.
- x1  in  col bits  left column.
- y1  in  row bits  bottom row.
- width  in  col bits  column count; 0 encodes PIXEL_WIDTH.
- height  in  row bits  row count; 0 encodes PIXEL_HEIGHT.
- row  out  row bits  RAM read row address.
- column  out  col bits  RAM read column address.
- pixel  out  pixel bits  RAM read byte select.
- ram_read_enable  out  1  read strobe; address valid this cycle.
- ram_access_start  out  1  one-cycle pulse on the first read of a command.
- ram_data_in  in  8  RAM read data, valid exactly 1 cycle after ram_read_enable.
- data_out  out  8  streamed byte.
- data_out_valid  out  1  data_out holds an unconsumed byte.
- data_out_ready  in  1  downstream accepts data_out when valid && ready.
- done  out  1  all bytes of the area accepted downstream.

Behaviour:
- Reset: state = IDLE (encoding 0). Every output is 0, including row, column, pixel, data_out and done.
- Reset mid-command: same result as reset. No further RAM reads; any pending byte is discarded.

Traversal order (identical to the fill path so a host can replay a readback):
- Rows run from y1+H-1 down to y1. Within a row, columns run x1+W-1 down to x1. Within a pixel, bytes run BYTES_PER_PIXEL-1 down to 0.
- Total bytes = W*H*BYTES_PER_PIXEL.
- Address arithmetic is modulo 2^bits; there is no clipping.

States:
- IDLE:
  - Enable sampled high and arm flag set -> ISSUE.
  - Latch x1, y1, W, H on that edge; inputs are don't-care afterwards.
- ISSUE:
  - ram_read_enable = 1 for exactly one cycle with the current address.
  - ram_access_start = 1 on the first ISSUE of the command only.
  - -> CAPTURE.
- CAPTURE:
  - Register ram_data_in into data_out; data_out_valid = 1 next cycle.
  - -> PRESENT.
- PRESENT:
  - Hold data_out stable while data_out_valid && !data_out_ready.
  - On a transfer (valid && ready), clear valid. If that was the last byte -> DONE; otherwise advance the address -> ISSUE.
- DONE:
  - done = 1, held.
  - ack high -> IDLE next cycle; done clears.

Latency and throughput:
- Enable edge to first data_out_valid = 3 cycles.
- Steady state: 1 byte per 3 cycles with data_out_ready tied high.

Handshake and re-arm rules:
- Arm flag clears on command start. It sets when enable is seen low in IDLE, so enable must go low for at least 1 cycle before a new command starts.
- enable low in ISSUE/CAPTURE/PRESENT aborts the command:
  - -> IDLE next cycle.
  - data_out_valid drops.
  - done never asserts.
- ack outside DONE is ignored.
- data_out_ready while !valid is ignored.

Optional Feature:
- Macro: READAREA_PREFETCH_EN.
- Defined:
  - Adds a 2-entry output FIFO.
  - A read is issued whenever the in-flight read count plus FIFO occupancy is < 2, so the block sustains 1 byte/cycle with ready held high.
  - First-byte latency stays 3 cycles.
  - FIFO full blocks issue.
  - Byte order, abort and reset behaviour are unchanged; abort and reset flush the FIFO.
  - done asserts the cycle after the last FIFO entry is accepted.
- Undefined: the single-buffer state machine above.

Test Plan:
Bench setup: PIXEL_WIDTH=4. The bench RAM model returns byte = {row, column, pixel} zero-extended, with 1-cycle latency.

1. Full-panel read:
   - Stimulus: x1=0, y1=0, width=0, height=0, ready=1.
   - Required: bytes arrive in descending address order, first byte = {PIXEL_HEIGHT-1, 3, BYTES_PER_PIXEL-1}. Count = 4*PIXEL_HEIGHT*BYTES_PER_PIXEL. Each row transition within 3*4*BYTES_PER_PIXEL cycles. ram_access_start pulses exactly once. done asserts.
2. Subarea read:
   - Stimulus: x1=1, y1=1, width=2, height=1.
   - Required: exactly 2*BYTES_PER_PIXEL bytes; column sequence 2 then 1; row stays 1.
3. Backpressure:
   - Stimulus: ready toggled 0/1 every 2 cycles.
   - Required: data_out stable while valid && !ready; no byte lost or duplicated; same byte stream as scenario 1.
4. Ack handshake:
   - Stimulus: after done, pulse ack 1 cycle, then drop enable.
   - Required: state==0 within 1 cycle; done=0. Re-raising enable starts a new command; holding enable high across ack does not.
5. Abort:
   - Stimulus: enable low after 3 bytes accepted.
   - Required: IDLE next cycle; valid=0; done never asserts; no further ram_read_enable.
6. Reset mid-command:
   - Stimulus: reset=1 for 1 cycle during PRESENT.
   - Required: all outputs 0 the next cycle; a fresh command afterwards produces the full scenario 1 stream.
